frac_clken_gen: RTL

- Multi-channel fractional clock-enable generator: derives up to CHANNELS independent rational-rate enables from one fabric clock.
- Each channel runs at Fout = Fclk * NUM / DEN, for example 12 MHz from 27 MHz with NUM=4, DEN=9.
- Serves slow peripheral domains (USB, audio, UART) without spending a PLL output per rate.
- Runtime reprogrammable, with a per-channel lock indication and global phase alignment.

---
 rtl/frac_clken_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frac_clken_gen.sv
// rtl/frac_clken_gen.sv - multi-channel fractional clock-enable generator
//
// Each channel produces ce at an average rate of num/den of the clkin rate.
// It does this with a modulo-den phase accumulator that steps by num every
// cycle. A channel in toggle mode also drives tgl, a roughly 50% duty square
// wave at half the ce rate.
//
// Ports:
//   clkin    fabric clock; all state changes on its rising edge
//   reset    asynchronous active-high reset
//   wr_en    configuration write strobe, one cycle per write
//   wr_ch    channel being written
//   wr_num   numerator (accumulator step)
//   wr_den   denominator (accumulator modulus)
//   wr_mode  0 = pulse mode, 1 = toggle mode
//   sync     global phase-align pulse
//   ce       per-channel single-cycle enable strobe (registered)
//   tgl      per-channel divided square wave, toggle mode only (registered)
//   locked   channel has strobed since its last configuration or reset
//   cfg_err  one-cycle pulse after a rejected write
module frac_clken_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16,
  parameter int CH_W     = 2
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [ACC_W-1:0]    wr_num,
  input  logic [ACC_W-1:0]    wr_den,
  input  logic                wr_mode,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] tgl,
  output logic [CHANNELS-1:0] locked,
  output logic                cfg_err
);

  // One extra bit makes the range check safe when CHANNELS == 2**CH_W.
  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

  // A write is accepted only when it addresses an existing channel and keeps
  // num <= den with den != 0. That guarantees acc < den, so a single
  // subtraction per cycle always brings the accumulator back into range.
  logic wr_ok;
  assign wr_ok = ({1'b0, wr_ch} < CH_LIMIT) &&
                 (wr_den != '0) &&
                 (wr_num <= wr_den);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ACC_W-1:0] num_r;
    logic [ACC_W-1:0] den_r;
    logic [ACC_W-1:0] acc_r;
    logic             mode_r;
    logic             ce_r;
    logic             tgl_r;
    logic             lock_r;

    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   rem;
    logic [ACC_W-1:0] acc_nxt;
    logic             hit;
    logic             sel;

    // The sum is one bit wider than the accumulator, so acc + num cannot
    // wrap even at num == den == 2**ACC_W - 1.
    assign sum     = {1'b0, acc_r} + {1'b0, num_r};
    assign hit     = (sum >= {1'b0, den_r});
    assign rem     = sum - {1'b0, den_r};
    assign acc_nxt = hit ? rem[ACC_W-1:0] : sum[ACC_W-1:0];

    assign sel = wr_en && wr_ok && (wr_ch == CH_W'(g));

    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        num_r  <= '0;
        den_r  <= ACC_W'(1);
        mode_r <= 1'b0;
        acc_r  <= '0;
        ce_r   <= 1'b0;
        tgl_r  <= 1'b0;
        lock_r <= 1'b0;
      end else if (sel) begin
        // New configuration restarts the channel from phase zero. The first
        // accumulation happens on the following edge.
        num_r  <= wr_num;
        den_r  <= wr_den;
        mode_r <= wr_mode;
        acc_r  <= '0;
        ce_r   <= 1'b0;
        tgl_r  <= 1'b0;
        lock_r <= 1'b0;
      end else if (sync) begin
        // Phase realignment keeps the configuration and the lock status.
        acc_r  <= '0;
        ce_r   <= 1'b0;
        tgl_r  <= 1'b0;
      end else begin
        acc_r  <= acc_nxt;
        ce_r   <= hit;
        // tgl flips on the same edge that raises ce. In pulse mode it is
        // held low.
        tgl_r  <= mode_r & (tgl_r ^ hit);
        lock_r <= lock_r | hit;
      end
    end

    assign ce[g]     = ce_r;
    assign tgl[g]    = tgl_r;
    assign locked[g] = lock_r;
  end

endmodule
